merge_frontier_fifo: RTL and testbench
======================================

MERGE_FRONTIER_FIFO -- requirements
Module: merge_frontier_fifo

Interface
REQ-001 SHALL have parameter NODE_IDX_WIDTH, default 10, width of the node index.
REQ-002 SHALL have parameter ACCUM_VAL_WIDTH, default 24, width of the per-node path-count value.
REQ-003 SHALL have parameter FIFO_DEPTH, default 32, entry count; power of two, minimum 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port flush, input, 1, synchronous clear of all entries.
REQ-007 SHALL have ports push_valid (in, 1), push_ready (out, 1), push_node (in, NODE_IDX_WIDTH) and push_val (in, ACCUM_VAL_WIDTH), forming the enqueue handshake.
REQ-008 SHALL have ports pop_valid (out, 1), pop_ready (in, 1), pop_node (out, NODE_IDX_WIDTH) and pop_val (out, ACCUM_VAL_WIDTH), forming the dequeue handshake.
REQ-009 SHALL have ports count (out, $clog2(FIFO_DEPTH)+1), full (out, 1), empty (out, 1), and sat_flag (out, 1, sticky saturation indicator).

Function
REQ-010 SHALL be a circular FIFO of (node, val) entries with read/write pointers one bit wider than the index; full and empty SHALL be derived from the pointers.
REQ-011 SHALL compare push_node against every occupied entry each cycle (CAM hit); at most one entry per node index SHALL ever be resident.
REQ-012 SHALL drive push_ready = !full | hit, combinationally from state and push_node only, never from pop_ready.
REQ-013 SHALL merge an accepted push that hits: add push_val to that entry's val in place, with no new entry and no count change.
REQ-014 SHALL write an accepted push that misses to the write pointer, then increment the write pointer and count.
REQ-015 SHALL saturate a merge sum at 2^ACCUM_VAL_WIDTH-1 and SHALL set sat_flag, which stays set until rst or flush.
REQ-016 SHALL drive pop_valid = !empty, with pop_node/pop_val showing the head entry; a pop fires on pop_valid & pop_ready.
REQ-017 SHALL make a missed push visible at the head no earlier than the next cycle; write-to-pop latency is 1 cycle when empty.
REQ-018 SHALL, on a simultaneous pop and push whose hit is the head entry, exclude the head from the hit: the pop returns the pre-merge value, and the push is treated as a miss (accepted only if !full).
REQ-019 SHALL, on a simultaneous pop and a push that misses, leave count unchanged; when full, push_ready remains low for a miss.
REQ-020 SHALL wrap pointers modulo FIFO_DEPTH without a bubble.
REQ-021 SHALL give flush priority over push and pop in the same cycle: pointers, count and sat_flag clear, and entries are discarded.
REQ-022 SHALL ignore push_node/push_val when push_valid is low, and SHALL not change state.

Reset
REQ-023 SHALL asynchronously clear the pointers, count, sat_flag and occupancy bits on rst; outputs SHALL then be pop_valid=0, empty=1, full=0, count=0, push_ready=1.
REQ-024 SHALL leave entry data storage unreset; pop_node/pop_val are don't-care while empty.
REQ-025 SHALL abandon an in-flight handshake when rst asserts mid-operation, with no partial merge retained.

Structure
REQ-026 SHALL take default parameter values and the node/value typedefs from the shared project package, alongside the existing digital_top constants.
REQ-027 SHALL isolate the CAM compare and hit-index encode in one sub-module, node_match_cam.
REQ-028 SHALL be 120-400 lines of RTL, with no vendor primitives.

Verification
REQ-029 SHALL cover in-order service: push (5,3), (9,1) into an empty FIFO -> pops return (5,3) then (9,1), count 2->0.
REQ-030 SHALL cover merge: push (5,3), then (5,4) -> count stays 1, pop returns (5,7).
REQ-031 SHALL cover full merge: fill with nodes 0..31 -> full=1; push (40,1) sees push_ready=0; push (7,2) is accepted and entry 7's val rises by 2.
REQ-032 SHALL cover head collision: head (5,3), simultaneous pop and push (5,4) -> pop returns (5,3), then a new tail entry (5,4) exists, count unchanged.
REQ-033 SHALL cover saturation: (2, 0xFFFFF0) merged with (2, 0x20) -> val 0xFFFFFF, sat_flag=1 until flush.
REQ-034 SHALL cover wrap-around and reset: 100 push/pop cycles wrap the pointers in order; mid-burst rst -> empty=1 immediately, then flush with push the same cycle -> empty=1.

Source files
------------

// File: rtl/merge_frontier_fifo_pkg.sv
// Shared defaults and entry typedefs for the merge frontier FIFO.
package merge_frontier_fifo_pkg;
  localparam int NODE_IDX_WIDTH_DEF  = 10;
  localparam int ACCUM_VAL_WIDTH_DEF = 24;
  localparam int FIFO_DEPTH_DEF      = 32;

  typedef logic [NODE_IDX_WIDTH_DEF-1:0]  node_t;
  typedef logic [ACCUM_VAL_WIDTH_DEF-1:0] val_t;

  typedef struct packed {
    node_t node;
    val_t  val;
  } entry_t;
endpackage

// File: rtl/merge_frontier_fifo_node_match_cam.sv
// Compares a key against every occupied entry and encodes the matching slot.
module node_match_cam
  import merge_frontier_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int NW    = NODE_IDX_WIDTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][NW-1:0] entry_node,
  input  logic [DEPTH-1:0]         occ,
  input  logic [NW-1:0]            key,
  output logic                     hit,
  output logic [AW-1:0]            hit_idx
);
  logic [DEPTH-1:0] match;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign match[i] = occ[i] && (entry_node[i] == key);
  end

  // At most one entry per node is resident, so a plain OR-encode is exact.
  always_comb begin
    hit     = |match;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (match[i]) hit_idx = AW'(i);
  end
endmodule

// File: rtl/merge_frontier_fifo.sv
// Frontier FIFO that merges pushes for an already-resident node by saturating add.
module merge_frontier_fifo
  import merge_frontier_fifo_pkg::*;
#(
  parameter int NODE_IDX_WIDTH  = NODE_IDX_WIDTH_DEF,
  parameter int ACCUM_VAL_WIDTH = ACCUM_VAL_WIDTH_DEF,
  parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          push_valid,
  output logic                          push_ready,
  input  logic [NODE_IDX_WIDTH-1:0]     push_node,
  input  logic [ACCUM_VAL_WIDTH-1:0]    push_val,
  output logic                          pop_valid,
  input  logic                          pop_ready,
  output logic [NODE_IDX_WIDTH-1:0]     pop_node,
  output logic [ACCUM_VAL_WIDTH-1:0]    pop_val,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty,
  output logic                          sat_flag
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int VW = ACCUM_VAL_WIDTH;

  logic [AW:0]                                wr_ptr, rd_ptr;
  logic [AW-1:0]                              wr_idx, rd_idx, hit_idx;
  logic [FIFO_DEPTH-1:0]                      occ;
  logic [FIFO_DEPTH-1:0][NODE_IDX_WIDTH-1:0]  node_mem;
  logic [FIFO_DEPTH-1:0][VW-1:0]              val_mem;
  logic                                       hit, head_hit;
  logic                                       pop_fire, push_fire, do_merge, do_write;
  logic [VW:0]                                sum;
  logic [VW-1:0]                              merged;

  node_match_cam #(.DEPTH(FIFO_DEPTH), .NW(NODE_IDX_WIDTH)) u_cam (
    .entry_node (node_mem),
    .occ        (occ),
    .key        (push_node),
    .hit        (hit),
    .hit_idx    (hit_idx)
  );

  assign wr_idx    = wr_ptr[AW-1:0];
  assign rd_idx    = rd_ptr[AW-1:0];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign count     = wr_ptr - rd_ptr;
  assign pop_valid = !empty;
  assign pop_node  = node_mem[rd_idx];
  assign pop_val   = val_mem[rd_idx];

  // A head hit may be popped this cycle, turning it into a miss; while full
  // such a push cannot be taken, so readiness only trusts non-head hits.
  assign head_hit   = hit && (hit_idx == rd_idx);
  assign push_ready = !full || (hit && !head_hit);
  assign pop_fire   = pop_valid && pop_ready;
  assign push_fire  = push_valid && push_ready;
  assign do_merge   = push_fire && hit && !(head_hit && pop_fire);
  assign do_write   = push_fire && !do_merge;

  assign sum    = {1'b0, val_mem[hit_idx]} + {1'b0, push_val};
  assign merged = sum[VW] ? '1 : sum[VW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      sat_flag <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (pop_fire) begin
        rd_ptr      <= rd_ptr + 1'b1;
        occ[rd_idx] <= 1'b0;
      end
      if (do_write) begin
        wr_ptr      <= wr_ptr + 1'b1;
        occ[wr_idx] <= 1'b1;
      end
      if (do_merge && sum[VW]) sat_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (do_write) begin
        node_mem[wr_idx] <= push_node;
        val_mem[wr_idx]  <= push_val;
      end
      if (do_merge) val_mem[hit_idx] <= merged;
    end
  end
endmodule

// File: tb/tb_merge_frontier_fifo.sv
// Directed scoreboard bench for merge_frontier_fifo at default parameters.
module tb_merge_frontier_fifo;
  import merge_frontier_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, push_valid, push_ready, pop_valid, pop_ready;
  logic        full, empty, sat_flag;
  node_t       push_node, pop_node;
  val_t        push_val, pop_val;
  logic [5:0]  count;

  int     checks = 0;
  int     errors = 0;
  entry_t expq[$];

  merge_frontier_fifo dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_node(push_node), .push_val(push_val),
    .pop_valid(pop_valid), .pop_ready(pop_ready),
    .pop_node(pop_node), .pop_val(pop_val),
    .count(count), .full(full), .empty(empty), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  // Monitor: a pop fires at the coming rising edge; sample mid-cycle.
  always @(negedge clk) begin
    if (!rst && pop_valid && pop_ready) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got node=%0d val=%0h, no pop expected", pop_node, pop_val);
      end else begin
        entry_t e;
        e = expq.pop_front();
        if (pop_node !== e.node || pop_val !== e.val) begin
          errors++;
          $display("FAIL pop_data got node=%0d val=%0h want node=%0d val=%0h",
                   pop_node, pop_val, e.node, e.val);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push(input int n, input int v);
    push_valid = 1'b1;
    push_node  = node_t'(n);
    push_val   = val_t'(v);
    step();
    push_valid = 1'b0;
  endtask

  task automatic pop_expect(input int n, input int v);
    expq.push_back('{node: node_t'(n), val: val_t'(v)});
    pop_ready = 1'b1;
    step();
    pop_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    push_node = '0; push_val = '0;
    step(); step();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_pop_valid", pop_valid, 0);
    rst = 1'b0;
    step();

    // in-order service
    push(5, 3);
    chk("latency_pop_valid", pop_valid, 1);
    push(9, 1);
    chk("inorder_count2", count, 2);
    pop_expect(5, 3);
    pop_expect(9, 1);
    chk("inorder_count0", count, 0);
    chk("inorder_empty", empty, 1);

    // ignored push data while push_valid low
    push_node = node_t'(77); push_val = val_t'(5);
    step();
    chk("idle_count", count, 0);

    // merge
    push(5, 3);
    push(5, 4);
    chk("merge_count", count, 1);
    pop_expect(5, 7);

    // full merge
    for (int i = 0; i < 32; i++) push(i, i + 16);
    chk("full_flag", full, 1);
    chk("full_count", count, 32);
    push_node = node_t'(40); #1;
    chk("full_miss_ready", push_ready, 0);
    push_node = node_t'(7); #1;
    chk("full_hit_ready", push_ready, 1);
    push(7, 2);
    chk("full_merge_count", count, 32);
    for (int i = 0; i < 32; i++) pop_expect(i, (i == 7) ? 25 : i + 16);
    chk("drain_empty", empty, 1);

    // head collision
    push(5, 3);
    expq.push_back('{node: node_t'(5), val: val_t'(3)});
    pop_ready = 1'b1;
    push(5, 4);
    pop_ready = 1'b0;
    chk("collide_count", count, 1);
    pop_expect(5, 4);
    chk("collide_empty", empty, 1);

    // saturation
    push(2, 'hFFFFF0);
    push(2, 'h20);
    chk("sat_flag_set", sat_flag, 1);
    chk("sat_count", count, 1);
    pop_expect(2, 'hFFFFFF);
    chk("sat_sticky", sat_flag, 1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("sat_flush_clear", sat_flag, 0);

    // wrap-around: steady push+pop keeps one entry resident
    push(100, 0);
    for (int k = 1; k <= 100; k++) begin
      expq.push_back('{node: node_t'(100 + k - 1), val: val_t'(k - 1)});
      pop_ready = 1'b1;
      push(100 + k, k);
    end
    pop_ready = 1'b0;
    chk("wrap_count", count, 1);
    push(300, 1);
    push(301, 2);
    chk("burst_count", count, 3);

    // asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("async_rst_empty", empty, 1);
    chk("async_rst_count", count, 0);
    step();
    rst = 1'b0;
    step();

    // flush wins over push
    push(3, 3);
    flush = 1'b1;
    push(4, 4);
    flush = 1'b0;
    chk("flush_push_empty", empty, 1);
    chk("flush_push_count", count, 0);

    step();
    chk("scoreboard_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
